arb8_rr: RTL and testbench

Round-robin arbiter that shares one 8:1-muxed resource (shared bus / read port) among eight requesters in the pipelined ARM datapath. It samples requests, grants exactly one owner at a time, and drives the 3-bit select of the downstream 8:1 mux. It holds the grant until the owner releases or a hold limit expires. A mandatory one-cycle turnaround separates grants so the mux output never switches mid-transfer.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 36 +++
 rtl/arb8_rr.sv | 88 ++++++++
 tb/tb_arb8_rr.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
// Holds the requester count, the select width, the FSM state type and a one-hot helper.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping,
// with ptr itself searched last.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           shift;
    logic [SEL_W-1:0]     pos;

    // Rotate so that bit 0 of rot is requester ptr+1.
    always_comb begin
        dbl   = {req, req};
        shift = {1'b0, ptr} + 4'd1;
        rot   = dbl[shift +: NUM_REQ];
    end

    always_comb begin
        pos = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = SEL_W'(j);
            end
        end
    end

    assign found = |req;
    assign idx   = ptr + SEL_W'(1) + pos;

endmodule

// File: rtl/arb8_rr.sv
// Round-robin arbiter for eight requesters sharing one 8:1-muxed resource.
// Registered one-hot grant and binary select, hold limit and one-cycle turnaround.
//
// state | meaning
// IDLE  | no owner; sample req and grant the round-robin winner
// OWN   | grant held; release on owner drop or hold limit
// TURN  | single dead cycle so the mux never switches mid-transfer
module arb8_rr
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               valid,
    output logic               timeout
);

    localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CW-1:0]    cnt;

    logic             found;
    logic [SEL_W-1:0] win;
    logic             rel_vol;
    logic             rel_forced;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    // A voluntary drop wins over the limit, so timeout only flags true revocations.
    assign rel_vol    = ~req[select];
    assign rel_forced = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= '0;
            select  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            ptr     <= 3'd7;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= onehot8(win);
                        select <= win;
                        valid  <= 1'b1;
                        ptr    <= win;
                        cnt    <= '0;
                        state  <= OWN;
                    end
                end
                OWN: begin
                    if (rel_vol || rel_forced) begin
                        grant   <= '0;
                        valid   <= 1'b0;
                        timeout <= rel_forced & ~rel_vol;
                        state   <= TURN;
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_rr.sv
// Self-checking bench for arb8_rr: table-driven vectors through a scoreboard queue,
// plus hand-written reset-mid-grant and unlimited-hold sequences.
module tb_arb8_rr;

    logic       clk;
    logic       reset_n;
    logic [7:0] req, req1;
    logic [7:0] grant, grant1;
    logic [2:0] select, select1;
    logic       valid, valid1;
    logic       timeout, timeout1;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    arb8_rr #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .select  (select),
        .valid   (valid),
        .timeout (timeout)
    );

    arb8_rr #(.MAX_HOLD(0)) dut_nolim (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req1),
        .grant   (grant1),
        .select  (select1),
        .valid   (valid1),
        .timeout (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [7:0] r, input logic [7:0] g,
                                input logic [2:0] s, input logic t);
        vec_t v;
        v.req = r; v.grant = g; v.sel = s; v.tmo = t;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        vec_t e;
        @(negedge clk);
        req = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d grant", n), grant, e.grant);
        chk($sformatf("v%0d select", n), {5'd0, select}, {5'd0, e.sel});
        chk($sformatf("v%0d valid", n), {7'd0, valid}, {7'd0, |e.grant});
        chk($sformatf("v%0d timeout", n), {7'd0, timeout}, {7'd0, e.tmo});
    endtask

    initial begin
        logic [7:0] oh;
        int nv;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        req = 8'h00;
        req1 = 8'h00;

        // Full rotation 0..7,0 with every owner dropping after one cycle.
        for (int k = 0; k < 9; k++) begin
            oh = 8'h01 << (k % 8);
            add(8'hFF, oh, 3'(k % 8), 1'b0);
            add(8'hFF & ~oh, 8'h00, 3'(k % 8), 1'b0);
            add(8'hFF, 8'h00, 3'(k % 8), 1'b0);
        end
        // Hold limit on requester 3: four grant cycles, timeout, re-grant after 2-cycle gap.
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h08, 8'h00, 3'd3, 1'b1);
        add(8'h08, 8'h00, 3'd3, 1'b0);
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h00, 8'h00, 3'd3, 1'b0);
        add(8'h00, 8'h00, 3'd3, 1'b0);
        // Owner 5, then 2 and 6 arrive: 6 before 2.
        add(8'h20, 8'h20, 3'd5, 1'b0);
        add(8'h64, 8'h20, 3'd5, 1'b0);
        add(8'h44, 8'h00, 3'd5, 1'b0);
        add(8'h44, 8'h00, 3'd5, 1'b0);
        add(8'h44, 8'h40, 3'd6, 1'b0);
        add(8'h04, 8'h00, 3'd6, 1'b0);
        add(8'h04, 8'h00, 3'd6, 1'b0);
        add(8'h04, 8'h04, 3'd2, 1'b0);
        add(8'h00, 8'h00, 3'd2, 1'b0);
        add(8'h00, 8'h00, 3'd2, 1'b0);
        // Owner 1 releases, 1 and 4 both pending: 4 first, then 1.
        add(8'h02, 8'h02, 3'd1, 1'b0);
        add(8'h00, 8'h00, 3'd1, 1'b0);
        add(8'h12, 8'h00, 3'd1, 1'b0);
        add(8'h12, 8'h10, 3'd4, 1'b0);
        add(8'h02, 8'h00, 3'd4, 1'b0);
        add(8'h02, 8'h00, 3'd4, 1'b0);
        add(8'h02, 8'h02, 3'd1, 1'b0);
        add(8'h00, 8'h00, 3'd1, 1'b0);
        add(8'h00, 8'h00, 3'd1, 1'b0);
        // Owner 6 granted; reset hits mid-grant below.
        add(8'h40, 8'h40, 3'd6, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst grant", grant, 8'h00);
        chk("rst select", {5'd0, select}, 8'h00);
        chk("rst valid", {7'd0, valid}, 8'h00);
        chk("rst timeout", {7'd0, timeout}, 8'h00);
        chk("rst grant nolim", grant1, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        nv = 0;
        foreach (vecs[i]) begin
            run_vec(vecs[i], nv);
            nv++;
        end

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async grant", grant, 8'h00);
        chk("async select", {5'd0, select}, 8'h00);
        chk("async valid", {7'd0, valid}, 8'h00);
        req = 8'h41;
        @(negedge clk);
        reset_n = 1'b1;
        vecs.delete();
        add(8'h41, 8'h01, 3'd0, 1'b0);
        add(8'h40, 8'h00, 3'd0, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0);
        foreach (vecs[i]) begin
            run_vec(vecs[i], nv);
            nv++;
        end

        // Unlimited hold: requester 2 keeps the grant for 50 cycles without timeout.
        @(negedge clk);
        req1 = 8'h04;
        @(posedge clk);
        #1;
        chk("nolim first grant", grant1, 8'h04);
        chk("nolim first select", {5'd0, select1}, 8'h02);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nolim hold %0d", c), grant1, 8'h04);
            chk($sformatf("nolim tmo %0d", c), {7'd0, timeout1}, 8'h00);
        end
        @(negedge clk);
        req1 = 8'h00;
        @(posedge clk);
        #1;
        chk("nolim release", grant1, 8'h00);
        chk("nolim release tmo", {7'd0, timeout1}, 8'h00);
        chk("nolim release sel", {5'd0, select1}, 8'h02);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
